// File: rtl/core_mem_pkg.sv
// Shared definitions for the data-memory responder: core status codes and
// the responder's phase encoding.
package core_mem_pkg;

  localparam logic [1:0] R_OK     = 2'd0;
  localparam logic [1:0] I_OK     = 2'd1;
  localparam logic [1:0] OVERFLOW = 2'd2;
  localparam logic [1:0] END      = 2'd3;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data memory: one synchronous write port, two combinational
// read ports (core side and dump side). Contents are never reset.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_ridx_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [IDX_W-1:0]  i_ridx_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_widx] <= i_wdata;
    end
  end

  assign o_rdata_a = mem_q[i_ridx_a];
  assign o_rdata_b = mem_q[i_ridx_b];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core data port: preload, serve core accesses, then
// stream out the final memory image once the core reports termination.
module dmem_responder
  import core_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_d_wen,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  input  logic [1:0]        i_status,
  input  logic              i_status_valid,
  input  logic              i_ld_valid,
  input  logic [IDX_W-1:0]  i_ld_idx,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_ld_done,
  output logic              o_ld_ready,
  output logic              o_run,
  output logic              o_dump_valid,
  output logic [IDX_W-1:0]  o_dump_idx,
  output logic [DATA_W-1:0] o_dump_data,
  input  logic              i_dump_ready,
  output logic              o_done,
  output logic [1:0]        o_final_status,
  output logic              o_err
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        fstat_q, fstat_d;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic [IDX_W-1:0]  core_idx;
  logic              addr_legal;

  assign core_idx   = i_d_addr[IDX_W+1:2];
  assign addr_legal = (i_d_addr[1:0] == 2'b00) && (i_d_addr < ADDR_W'(DEPTH * 4));

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .i_clk     (i_clk),
    .i_we      (mem_we),
    .i_widx    (mem_widx),
    .i_wdata   (mem_wdata),
    .i_ridx_a  (core_idx),
    .o_rdata_a (core_rdata),
    .i_ridx_b  (cnt_q),
    .o_rdata_b (o_dump_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    fstat_d   = fstat_q;
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    case (state_q)
      S_LOAD: begin
        if (i_ld_valid) begin
          mem_we    = 1'b1;
          mem_widx  = i_ld_idx;
          mem_wdata = i_ld_data;
        end
        if (i_ld_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (i_d_wen) begin
          if (addr_legal) begin
            mem_we    = 1'b1;
            mem_widx  = core_idx;
            mem_wdata = i_d_wdata;
          end else begin
            err_d = 1'b1;
          end
        end
        // Only terminating codes end the run; R_OK / I_OK are progress reports.
        if (i_status_valid && (i_status == OVERFLOW || i_status == END)) begin
          fstat_d = i_status;
          state_d = S_DUMP;
        end
      end
      S_DUMP: begin
        if (i_dump_ready) begin
          cnt_d = cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fstat_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fstat_q <= fstat_d;
    end
  end

  // The core drives ALU results on the address bus, so illegal reads are quiet zeros.
  assign o_d_rdata      = addr_legal ? core_rdata : '0;
  assign o_ld_ready     = (state_q == S_LOAD);
  assign o_run          = (state_q == S_RUN);
  assign o_dump_valid   = (state_q == S_DUMP);
  assign o_done         = (state_q == S_DONE);
  assign o_dump_idx     = cnt_q;
  assign o_final_status = fstat_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed-plus-random bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int IDX_W = 6;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_d_wen;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_wdata;
  logic [31:0] o_d_rdata;
  logic [1:0]  i_status;
  logic        i_status_valid;
  logic        i_ld_valid;
  logic [IDX_W-1:0] i_ld_idx;
  logic [31:0] i_ld_data;
  logic        i_ld_done;
  logic        o_ld_ready;
  logic        o_run;
  logic        o_dump_valid;
  logic [IDX_W-1:0] o_dump_idx;
  logic [31:0] o_dump_data;
  logic        i_dump_ready;
  logic        o_done;
  logic [1:0]  o_final_status;
  logic        o_err;

  always #5 i_clk = ~i_clk;

  dmem_responder dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_d_wen        (i_d_wen),
    .i_d_addr       (i_d_addr),
    .i_d_wdata      (i_d_wdata),
    .o_d_rdata      (o_d_rdata),
    .i_status       (i_status),
    .i_status_valid (i_status_valid),
    .i_ld_valid     (i_ld_valid),
    .i_ld_idx       (i_ld_idx),
    .i_ld_data      (i_ld_data),
    .i_ld_done      (i_ld_done),
    .o_ld_ready     (o_ld_ready),
    .o_run          (o_run),
    .o_dump_valid   (o_dump_valid),
    .o_dump_idx     (o_dump_idx),
    .o_dump_data    (o_dump_data),
    .i_dump_ready   (i_dump_ready),
    .o_done         (o_done),
    .o_final_status (o_final_status),
    .o_err          (o_err)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (a[1:0] == 2'b00 && a < DEPTH * 4) return model[a / 4];
    return 32'd0;
  endfunction

  task automatic random_reads(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      i_d_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      settle();
      chk(tag, o_d_rdata, ref_read(i_d_addr));
    end
  endtask

  initial begin
    i_rst = 1'b1; i_d_wen = 1'b0; i_d_addr = '0; i_d_wdata = '0;
    i_status = '0; i_status_valid = 1'b0; i_ld_valid = 1'b0; i_ld_idx = '0;
    i_ld_data = '0; i_ld_done = 1'b0; i_dump_ready = 1'b0;
    tick(); tick();
    i_rst = 1'b0;
    settle();
    chk("rst_ld_ready", 32'(o_ld_ready), 32'd1);
    chk("rst_run", 32'(o_run), 32'd0);
    chk("rst_dump_valid", 32'(o_dump_valid), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_final", 32'(o_final_status), 32'd0);

    // Load every word; a core write mid-load must be ignored; done shares the last cycle.
    for (int i = 0; i < DEPTH; i++) begin
      i_ld_valid = 1'b1;
      i_ld_idx   = IDX_W'(i);
      i_ld_data  = (i < 4) ? 32'((i + 1) * 11) : $urandom;
      model[i]   = i_ld_data;
      i_d_wen    = (i == 20);
      i_d_addr   = 32'd0;
      i_d_wdata  = 32'hBAD;
      i_ld_done  = (i == DEPTH - 1);
      tick();
    end
    i_ld_valid = 1'b0; i_ld_done = 1'b0; i_d_wen = 1'b0;
    settle();
    chk("run_after_load", 32'(o_run), 32'd1);
    chk("ld_ready_after_load", 32'(o_ld_ready), 32'd0);
    i_d_addr = 32'd8; settle();
    chk("read_addr8", o_d_rdata, 32'd33);
    i_d_addr = 32'd0; settle();
    chk("load_core_write_ignored", o_d_rdata, 32'd11);
    random_reads("rand_read_run", 24);

    i_d_wen = 1'b1; i_d_addr = 32'd4; i_d_wdata = 32'hDEAD;
    settle();
    chk("same_cycle_old_data", o_d_rdata, 32'd22);
    tick();
    i_d_wen = 1'b0; model[1] = 32'hDEAD;
    settle();
    chk("read_after_write", o_d_rdata, 32'hDEAD);

    i_ld_valid = 1'b1; i_ld_idx = IDX_W'(1); i_ld_data = 32'h999;
    tick();
    i_ld_valid = 1'b0; settle();
    chk("loader_ignored_in_run", o_d_rdata, 32'hDEAD);

    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = $urandom_range(0, DEPTH - 1);
      i_d_wen = 1'b1; i_d_addr = 32'(idx * 4); i_d_wdata = $urandom;
      settle();
      chk("rand_write_old", o_d_rdata, model[idx]);
      tick();
      model[idx] = i_d_wdata;
      i_d_wen = 1'b0;
      random_reads("rand_read_after_write", 2);
    end

    for (int c = 0; c < 2; c++) begin
      i_status_valid = 1'b1; i_status = 2'(c);
      tick();
    end
    i_status_valid = 1'b0; settle();
    chk("nonterminal_status_ignored", 32'(o_run), 32'd1);

    chk("err_clear_before_illegal", 32'(o_err), 32'd0);
    i_d_wen = 1'b1; i_d_addr = 32'd6; i_d_wdata = 32'h55;
    tick();
    chk("err_misaligned", 32'(o_err), 32'd1);
    i_d_addr = 32'd256;
    tick();
    i_d_wen = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    settle();
    chk("err_sticky", 32'(o_err), 32'd1);
    chk("read_256_zero", o_d_rdata, 32'd0);
    i_d_addr = 32'd4; settle();
    chk("misaligned_write_dropped", o_d_rdata, model[1]);
    random_reads("rand_read_after_illegal", 8);

    i_status_valid = 1'b1; i_status = 2'd3;
    i_d_wen = 1'b1; i_d_addr = 32'd0; i_d_wdata = 32'd7;
    tick();
    i_status_valid = 1'b0; i_d_wen = 1'b0; model[0] = 32'd7;
    settle();
    chk("dump_valid_start", 32'(o_dump_valid), 32'd1);
    chk("run_low_in_dump", 32'(o_run), 32'd0);
    chk("final_status_end", 32'(o_final_status), 32'd3);
    chk("dump_first_idx", 32'(o_dump_idx), 32'd0);
    chk("dump_first_data", o_dump_data, 32'd7);

    begin
      int exp_idx;
      int cycles;
      exp_idx = 0; cycles = 0;
      while (exp_idx < DEPTH && cycles < 400) begin
        i_dump_ready = cycles[0];
        settle();
        chk("dump_valid", 32'(o_dump_valid), 32'd1);
        chk("dump_done_low", 32'(o_done), 32'd0);
        chk("dump_idx", 32'(o_dump_idx), 32'(exp_idx));
        chk("dump_data", o_dump_data, model[exp_idx]);
        if (i_dump_ready) exp_idx++;
        tick();
        cycles++;
      end
      i_dump_ready = 1'b0;
      chk("dump_all_words", 32'(exp_idx), 32'(DEPTH));
    end
    settle();
    chk("done_after_dump", 32'(o_done), 32'd1);
    chk("dump_valid_after_done", 32'(o_dump_valid), 32'd0);
    tick(); settle();
    chk("done_holds", 32'(o_done), 32'd1);

    // Second run: terminate on overflow and reset partway through the dump.
    i_rst = 1'b1; tick(); i_rst = 1'b0; settle();
    chk("rerun_ld_ready", 32'(o_ld_ready), 32'd1);
    chk("rerun_done_low", 32'(o_done), 32'd0);
    i_ld_done = 1'b1; tick(); i_ld_done = 1'b0; settle();
    chk("rerun_run", 32'(o_run), 32'd1);
    i_d_wen = 1'b1; i_d_addr = 32'd300; i_d_wdata = 32'h1;
    tick();
    i_d_addr = 32'd40; i_d_wdata = $urandom;
    tick();
    model[10] = i_d_wdata; i_d_wen = 1'b0;
    chk("rerun_err", 32'(o_err), 32'd1);
    i_status_valid = 1'b1; i_status = 2'd2;
    tick();
    i_status_valid = 1'b0; settle();
    chk("final_status_overflow", 32'(o_final_status), 32'd2);
    i_dump_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    i_dump_ready = 1'b0; settle();
    chk("mid_dump_idx", 32'(o_dump_idx), 32'd10);
    chk("mid_dump_data", o_dump_data, model[10]);
    i_rst = 1'b1; tick(); i_rst = 1'b0; settle();
    chk("mid_rst_ld_ready", 32'(o_ld_ready), 32'd1);
    chk("mid_rst_dump_valid", 32'(o_dump_valid), 32'd0);
    chk("mid_rst_err", 32'(o_err), 32'd0);
    chk("mid_rst_final", 32'(o_final_status), 32'd0);
    chk("mid_rst_run", 32'(o_run), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      i_d_addr = 32'(i * 4); settle();
      chk("mem_survives_reset", o_d_rdata, model[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
